pulse_freq_counter: RTL and testbench
=====================================

# pulse_freq_counter

Front-end measurement stage of the Neptune proportional tuner. It conditions the raw `input_pulse` pin with a synchronizer and glitch filter, then counts filtered rising edges over a gate window whose length is set by `clk_config`. Each finished window is handed to the downstream note classifier and display stage through a valid/ready register.

## Interface
- `CNT_W`, default 8: width of the edge count result.
- `WIN_W`, default 24: width of the gate-window cycle counter; must satisfy `2^WIN_W > BASE_WINDOW<<7`.
- `BASE_WINDOW`, default 4096: gate length in clock cycles when `clk_config`=0.
- `FILTER`, default 2: number of consecutive equal samples required to change the filtered level (≥1).
- `clk`, input, 1: single clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `clk_config`, input, 3: window scale; gate length = `BASE_WINDOW << clk_config`.
- `pulse_in`, input, 1: asynchronous squared audio signal.
- `count`, output, CNT_W: edges counted in the last completed window.
- `count_valid`, output, 1: `count` holds an unconsumed result.
- `count_ready`, input, 1: consumer accepts the result when high together with `count_valid`.
- `saturated`, output, 1: qualifies `count`; the edge counter hit `2^CNT_W-1` during that window.
- `overrun`, output, 1: sticky; an unconsumed result was overwritten.

## Operation
- Synchronizer: 2 flops on `pulse_in`. Reset value 0.
- Glitch filter FSM with states LOW, PEND_HI, HIGH, and PEND_LO. Reset state is LOW.
  - LOW→PEND_HI on a synced 1. PEND_HI→HIGH after FILTER consecutive 1s; PEND_HI→LOW on any 0.
  - HIGH→PEND_LO on a 0. PEND_LO→LOW after FILTER consecutive 0s; PEND_LO→HIGH on any 1.
  - With FILTER=1, PEND states are bypassed.
  - An `edge` strobe of one cycle is issued on the LOW/PEND_HI→HIGH transition only.
- Gate window:
  - `clk_config` is latched at each window start. A change mid-window takes effect at the next window.
  - The window counter counts down from `(BASE_WINDOW<<cfg)-1` to 0, then reloads. Windows are back-to-back with no dead cycle.
- Edge counter:
  - Increments on `edge` and saturates at `2^CNT_W-1`, setting an internal sat bit.
  - An edge in the final window cycle counts toward the current window.
  - At the final cycle, the counter and sat bit are transferred to the result register and cleared. An edge in that same cycle is included in the transferred value.
- Result register handshake:
  - Load sets `count_valid`. A handshake (`count_valid & count_ready`) clears `count_valid` unless a load occurs in the same cycle.
  - Load while `count_valid` is high and `count_ready` is low: the old result is overwritten and `overrun` is set to 1.
  - Load with `count_ready` high: the old result is accepted, the new one is loaded, `count_valid` stays 1, and `overrun` is unchanged.
  - `overrun` clears on the first handshake after it was set. A handshake that is simultaneously an overrun load leaves it set.
- Reset values:
  - `count`=0, `count_valid`=0, `saturated`=0, `overrun`=0.
  - Filter is in LOW; edge counter is 0.
  - Window counter is loaded for `clk_config` sampled during reset.
- Reset mid-window discards the partial window and any pending result. The first window starts on the first clock after deassertion.

## Timing
- Pin to `edge`: 2 sync cycles + FILTER cycles; with FILTER=2, `edge` is asserted 4 cycles after the pin rises at a clock edge.
- `count_valid` rises 1 cycle after the final window cycle, so the first result appears at cycle `BASE_WINDOW<<cfg` after reset release.
- Result period is exactly `BASE_WINDOW<<cfg` cycles.
- The consumer has until the next load to accept a result.
- `count`, `saturated`, and `overrun` are registered. No combinational path from `count_ready` to any output other than through the flops.

## Structure
- `neptune_pkg`: filter state enum (LOW, PEND_HI, HIGH, PEND_LO) and default values for CNT_W, WIN_W, BASE_WINDOW, and FILTER.
- Sub-module `pulse_glitch_filter`: the synchronizer plus filter FSM; outputs `level` and `edge`.
- The top level holds the window counter, edge counter, and result handshake.

## Test plan
- Reset behaviour: BASE_WINDOW=16, FILTER=2, cfg=0, `count_ready`=1, `pulse_in` 2 high/2 low → after the first window, every result is `count`=4 every 16 cycles, with `saturated`=0 and `overrun`=0.
- Glitch rejection: 1-cycle pulses every 8 cycles with FILTER=2 → `count`=0. With FILTER=1 → `count`=2 per 16-cycle window.
- Window scaling: cfg switched 0→2 mid-window → the current window stays 16 cycles, the next is 64 cycles, and `count`=16 for a period of 4.
- Saturation: CNT_W=4, period 2 with FILTER=1, cfg=2 → `count`=15 and `saturated`=1; next window at cfg=0 → `count`=8 and `saturated`=0.
- Handshake and overrun:
  - Hold `count_ready`=0 for two windows → `count` equals the second result and `overrun`=1.
  - Pulse `count_ready` → `count_valid` falls and `overrun` clears.
  - Assert `count_ready` on the load cycle → `count_valid` stays 1 and `overrun` stays 0.
- Async reset: assert `reset` at cycle 7 of a window → outputs go to 0 immediately without a clock. After release, the first result appears 16 cycles later.

Source files
------------

// File: rtl/neptune_pkg.sv
// neptune_pkg: shared filter state type and parameter defaults for the Neptune pulse front end
package neptune_pkg;
  typedef enum logic [1:0] {LOW, PEND_HI, HIGH, PEND_LO} filt_state_t;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_WIN_W       = 24;
  localparam int DEF_BASE_WINDOW = 4096;
  localparam int DEF_FILTER      = 2;
endpackage

// File: rtl/pulse_freq_counter_if.sv
// pulse_freq_counter_if: valid/ready result channel from the frequency counter to its consumer
interface pulse_freq_counter_if
  import neptune_pkg::*;
#(parameter int CNT_W = DEF_CNT_W);
  logic [CNT_W-1:0] count;
  logic             count_valid;
  logic             count_ready;
  logic             saturated;
  logic             overrun;
  modport master (output count, count_valid, saturated, overrun, input count_ready);
  modport slave  (input count, count_valid, saturated, overrun, output count_ready);
endinterface

// File: rtl/pulse_glitch_filter.sv
// pulse_glitch_filter: two-flop synchronizer plus debounce FSM; o_edge strobes once per qualified rising level
module pulse_glitch_filter
  import neptune_pkg::*;
#(parameter int FILTER = DEF_FILTER) (
  input  logic clk,
  input  logic reset,
  input  logic i_pulse,
  output logic o_level,
  output logic o_edge
);
  localparam int FW = FILTER > 1 ? $clog2(FILTER) : 1;
  logic [1:0]    r_sync;
  filt_state_t   r_state;
  logic [FW-1:0] r_cnt;
  logic          w_s, w_done;
  assign w_s    = r_sync[1];
  assign w_done = r_cnt == FW'(FILTER - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_sync  <= '0;
      r_state <= LOW;
      r_cnt   <= '0;
      o_level <= 1'b0;
      o_edge  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_pulse};
      o_edge <= 1'b0;
      case (r_state)
        LOW:
          if (w_s) begin
            if (FILTER == 1) begin
              r_state <= HIGH;
              o_level <= 1'b1;
              o_edge  <= 1'b1;
            end else begin
              r_state <= PEND_HI;
              r_cnt   <= FW'(1);
            end
          end
        PEND_HI:
          if (!w_s) r_state <= LOW;
          else if (w_done) begin
            r_state <= HIGH;
            o_level <= 1'b1;
            o_edge  <= 1'b1;
          end else r_cnt <= r_cnt + FW'(1);
        HIGH:
          if (!w_s) begin
            if (FILTER == 1) begin
              r_state <= LOW;
              o_level <= 1'b0;
            end else begin
              r_state <= PEND_LO;
              r_cnt   <= FW'(1);
            end
          end
        PEND_LO:
          // a returning 1 cancels the fall without a new edge strobe
          if (w_s) r_state <= HIGH;
          else if (w_done) begin
            r_state <= LOW;
            o_level <= 1'b0;
          end else r_cnt <= r_cnt + FW'(1);
      endcase
    end
endmodule

// File: rtl/pulse_freq_counter.sv
// pulse_freq_counter: counts filtered rising edges per gate window of BASE_WINDOW<<clk_config cycles
// and hands each finished window to the consumer through a valid/ready result register.
module pulse_freq_counter
  import neptune_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WIN_W       = DEF_WIN_W,
  parameter int BASE_WINDOW = DEF_BASE_WINDOW,
  parameter int FILTER      = DEF_FILTER
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           clk_config,
  input  logic                 pulse_in,
  pulse_freq_counter_if.master bus
);
  localparam logic [WIN_W-1:0] BASE = WIN_W'(BASE_WINDOW);
  localparam logic [CNT_W-1:0] MAX  = '1;
  logic             w_edge, w_unused_level;
  logic [2:0]       r_cfg, w_cfg;
  logic [WIN_W-1:0] r_win, w_last;
  logic [CNT_W-1:0] r_ecnt, w_cnt_nx;
  logic             r_sat, w_sat_nx, w_final, w_hs;
  pulse_glitch_filter #(.FILTER(FILTER)) u_filt (
    .clk     (clk),
    .reset   (reset),
    .i_pulse (pulse_in),
    .o_level (w_unused_level),
    .o_edge  (w_edge)
  );
  // the first cycle of each window (r_win==0) takes clk_config live and latches it
  assign w_cfg    = r_win == '0 ? clk_config : r_cfg;
  assign w_last   = (BASE << w_cfg) - WIN_W'(1);
  assign w_final  = r_win == w_last;
  assign w_cnt_nx = r_ecnt + CNT_W'(w_edge && r_ecnt != MAX);
  assign w_sat_nx = r_sat | (w_cnt_nx == MAX);
  assign w_hs     = bus.count_valid & bus.count_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cfg           <= '0;
      r_win           <= '0;
      r_ecnt          <= '0;
      r_sat           <= 1'b0;
      bus.count       <= '0;
      bus.count_valid <= 1'b0;
      bus.saturated   <= 1'b0;
      bus.overrun     <= 1'b0;
    end else begin
      r_cfg  <= w_cfg;
      r_win  <= w_final ? '0 : r_win + WIN_W'(1);
      r_ecnt <= w_final ? '0 : w_cnt_nx;
      r_sat  <= ~w_final & w_sat_nx;
      if (w_final) begin
        bus.count     <= w_cnt_nx;
        bus.saturated <= w_sat_nx;
      end
      bus.count_valid <= w_final | (bus.count_valid & ~bus.count_ready);
      // a load with ready high neither sets nor clears the sticky flag
      bus.overrun <= (w_final & bus.count_valid & ~bus.count_ready) | (bus.overrun & (w_final | ~w_hs));
    end
endmodule

// File: tb/tb_pulse_freq_counter.sv
// tb_pulse_freq_counter: directed checks of three counter instances sharing one pulse pin
module tb_pulse_freq_counter;
  logic       clk = 1'b0, reset = 1'b1, pin = 1'b0;
  logic [2:0] cfg0 = 3'd0, cfg1 = 3'd0, cfg2 = 3'd0;
  int per = 0, hi = 0, ph = 0, total = 0, pass = 0;

  typedef struct {
    int per;
    int hi;
    int exp0;
    int exp1;
  } vec_t;
  vec_t tbl[8];

  pulse_freq_counter_if #(.CNT_W(8)) b0 ();
  pulse_freq_counter_if #(.CNT_W(8)) b1 ();
  pulse_freq_counter_if #(.CNT_W(4)) b2 ();

  pulse_freq_counter #(.CNT_W(8), .WIN_W(24), .BASE_WINDOW(16), .FILTER(2)) u0 (
    .clk(clk), .reset(reset), .clk_config(cfg0), .pulse_in(pin), .bus(b0));
  pulse_freq_counter #(.CNT_W(8), .WIN_W(24), .BASE_WINDOW(16), .FILTER(1)) u1 (
    .clk(clk), .reset(reset), .clk_config(cfg1), .pulse_in(pin), .bus(b1));
  pulse_freq_counter #(.CNT_W(4), .WIN_W(24), .BASE_WINDOW(16), .FILTER(1)) u2 (
    .clk(clk), .reset(reset), .clk_config(cfg2), .pulse_in(pin), .bus(b2));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #2;
    ph++;
    pin = (per != 0) && ((ph % per) < hi);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  initial begin
    tbl[0] = '{4, 2, 4, 4};
    tbl[1] = '{8, 1, 0, 2};
    tbl[2] = '{8, 4, 2, 2};
    tbl[3] = '{16, 8, 1, 1};
    tbl[4] = '{8, 7, 0, 2};
    tbl[5] = '{4, 4, 0, 0};
    tbl[6] = '{8, 6, 2, 2};
    tbl[7] = '{2, 1, 0, 8};
    b0.count_ready = 1'b1;
    b1.count_ready = 1'b1;
    b2.count_ready = 1'b1;
    step(3);
    chk("reset count", int'(b0.count), 0);
    chk("reset valid", int'(b0.count_valid), 0);
    chk("reset sat", int'(b0.saturated), 0);
    chk("reset overrun", int'(b0.overrun), 0);
    reset = 1'b0;
    step(15);
    chk("first window not yet done", int'(b0.count_valid), 0);
    step(1);
    chk("first window valid", int'(b0.count_valid), 1);
    chk("first window count", int'(b0.count), 0);

    for (int i = 0; i < 8; i++) begin
      per = tbl[i].per;
      hi = tbl[i].hi;
      step(32);
      chk($sformatf("tbl%0d f2 count", i), int'(b0.count), tbl[i].exp0);
      chk($sformatf("tbl%0d f1 count", i), int'(b1.count), tbl[i].exp1);
      chk($sformatf("tbl%0d w4 count", i), int'(b2.count), tbl[i].exp1);
      chk($sformatf("tbl%0d f2 valid", i), int'(b0.count_valid), 1);
      chk($sformatf("tbl%0d f2 sat", i), int'(b0.saturated), 0);
      chk($sformatf("tbl%0d f2 overrun", i), int'(b0.overrun), 0);
    end

    cfg2 = 3'd2;
    step(64);
    chk("sat count", int'(b2.count), 15);
    chk("sat flag", int'(b2.saturated), 1);
    cfg2 = 3'd0;
    step(16);
    chk("post sat count", int'(b2.count), 8);
    chk("post sat flag", int'(b2.saturated), 0);

    per = 4;
    hi = 2;
    step(24);
    cfg0 = 3'd2;
    step(8);
    chk("scale old window count", int'(b0.count), 4);
    step(1);
    b0.count_ready = 1'b0;
    chk("scale accepted", int'(b0.count_valid), 0);
    step(62);
    chk("scale long window pending", int'(b0.count_valid), 0);
    step(1);
    chk("scale long window valid", int'(b0.count_valid), 1);
    chk("scale long window count", int'(b0.count), 16);
    cfg0 = 3'd0;

    step(16);
    chk("overrun count", int'(b0.count), 4);
    chk("overrun set", int'(b0.overrun), 1);
    chk("overrun valid", int'(b0.count_valid), 1);
    b0.count_ready = 1'b1;
    step(1);
    b0.count_ready = 1'b0;
    chk("handshake valid low", int'(b0.count_valid), 0);
    chk("handshake overrun clear", int'(b0.overrun), 0);
    step(15);
    chk("reload valid", int'(b0.count_valid), 1);
    chk("reload no overrun", int'(b0.overrun), 0);
    step(15);
    b0.count_ready = 1'b1;
    step(1);
    b0.count_ready = 1'b0;
    chk("ready on load valid", int'(b0.count_valid), 1);
    chk("ready on load overrun", int'(b0.overrun), 0);
    chk("ready on load count", int'(b0.count), 4);
    step(16);
    chk("second overrun set", int'(b0.overrun), 1);
    step(15);
    b0.count_ready = 1'b1;
    step(1);
    b0.count_ready = 1'b0;
    chk("ready on load keeps overrun", int'(b0.overrun), 1);
    chk("ready on load keeps valid", int'(b0.count_valid), 1);

    step(7);
    reset = 1'b1;
    #1;
    chk("async reset count", int'(b0.count), 0);
    chk("async reset valid", int'(b0.count_valid), 0);
    chk("async reset overrun", int'(b0.overrun), 0);
    step(2);
    reset = 1'b0;
    b0.count_ready = 1'b1;
    step(15);
    chk("post reset pending", int'(b0.count_valid), 0);
    step(1);
    chk("post reset first result", int'(b0.count_valid), 1);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
